// File: rtl/bp_pkg.sv
// Shared branch-prediction types: control-flow kinds, 2-bit counter states,
// and the default-geometry BTB entry layout.
package bp_pkg;

  localparam int BP_WIDTH    = 32;
  localparam int BP_TAG_BITS = 8;

  typedef enum logic [1:0] {
    COND = 2'b00,
    JUMP = 2'b01,
    CALL = 2'b10,
    RET  = 2'b11
  } cf_type_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_BITS-1:0] tag;
    logic [BP_WIDTH-1:0]    target;
    cf_type_e               cf_type;
    logic [1:0]             ctr;
  } btb_entry_t;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    if (taken) result = (ctr == ST)  ? ST  : ctr + 2'd1;
    else       result = (ctr == SNT) ? SNT : ctr - 2'd1;
    return result;
  endfunction

endpackage

// File: rtl/next_pc_predictor_ras.sv
// Circular return address stack: a push when full overwrites the oldest
// entry, a pop when empty is ignored.
module return_address_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stack_reg [DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;

  // ptr_reg names the next free slot, so the top lives one slot behind it.
  assign ptr_inc = (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + PTR_W'(1);
  assign ptr_dec = (ptr_reg == '0) ? PTR_W'(DEPTH - 1) : ptr_reg - PTR_W'(1);
  assign top     = stack_reg[ptr_dec];
  assign empty   = (count_reg == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (push) begin
      ptr_reg   <= ptr_inc;
      count_reg <= (count_reg == CNT_W'(DEPTH)) ? count_reg : count_reg + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_reg   <= ptr_dec;
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) stack_reg[ptr_reg] <= push_data;
  end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch-stage PC generator: PC register, direct-mapped BTB with 2-bit
// counters, return address stack and EX-stage mispredict redirect.
module next_pc_predictor
  import bp_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               BTB_ENTRIES = 16,
  parameter int               TAG_BITS    = 8,
  parameter int               RAS_DEPTH   = 4,
  parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_F,
  input  logic             resolve_valid_EX,
  input  logic [WIDTH-1:0] resolve_pc_EX,
  input  logic [1:0]       resolve_type_EX,
  input  logic             resolve_taken_EX,
  input  logic [WIDTH-1:0] resolve_target_EX,
  input  logic             resolve_pred_taken_EX,
  input  logic [WIDTH-1:0] resolve_pred_target_EX,
  output logic [WIDTH-1:0] pc_F,
  output logic             pred_taken_F,
  output logic [WIDTH-1:0] pred_target_F,
  output logic             mispredict_EX
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  // Valid bits live apart from the payload so only they need clearing on reset.
  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [WIDTH-1:0]    target;
    cf_type_e            cf_type;
    logic [1:0]          ctr;
  } btb_line_t;

  logic [BTB_ENTRIES-1:0] valid_reg;
  btb_line_t              btb_reg [BTB_ENTRIES];
  logic [WIDTH-1:0]       pc_reg;

  logic [IDX-1:0]      f_idx;
  logic [TAG_BITS-1:0] f_tag;
  btb_line_t           f_line;
  logic                f_hit;
  logic [WIDTH-1:0]    pc_plus4;

  logic [IDX-1:0]      r_idx;
  logic [TAG_BITS-1:0] r_tag;
  btb_line_t           r_line;
  logic                r_hit;
  cf_type_e            r_type;
  logic [WIDTH-1:0]    redirect_pc;

  logic             btb_we;
  btb_line_t        btb_wdata;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;

  assign pc_F     = pc_reg;
  assign pc_plus4 = pc_reg + WIDTH'(4);

  assign f_idx  = pc_reg[IDX+1:2];
  assign f_tag  = pc_reg[IDX+TAG_BITS+1:IDX+2];
  assign f_line = btb_reg[f_idx];
  assign f_hit  = valid_reg[f_idx] && (f_line.tag == f_tag);

  always_comb begin
    pred_taken_F  = 1'b0;
    pred_target_F = pc_plus4;
    if (f_hit) begin
      case (f_line.cf_type)
        COND: begin
          if (f_line.ctr[1]) begin
            pred_taken_F  = 1'b1;
            pred_target_F = f_line.target;
          end
        end
        JUMP, CALL: begin
          pred_taken_F  = 1'b1;
          pred_target_F = f_line.target;
        end
        RET: begin
          pred_taken_F  = 1'b1;
          pred_target_F = ras_empty ? f_line.target : ras_top;
        end
        default: ;
      endcase
    end
  end

  assign r_idx  = resolve_pc_EX[IDX+1:2];
  assign r_tag  = resolve_pc_EX[IDX+TAG_BITS+1:IDX+2];
  assign r_line = btb_reg[r_idx];
  assign r_hit  = valid_reg[r_idx] && (r_line.tag == r_tag);
  assign r_type = cf_type_e'(resolve_type_EX);

  assign mispredict_EX = resolve_valid_EX &&
                         ((resolve_taken_EX != resolve_pred_taken_EX) ||
                          (resolve_taken_EX && (resolve_target_EX != resolve_pred_target_EX)));
  assign redirect_pc   = resolve_taken_EX ? resolve_target_EX : resolve_pc_EX + WIDTH'(4);

  // Hits always refresh the entry; misses allocate only when taken.
  assign btb_we = resolve_valid_EX && (r_hit || resolve_taken_EX);

  always_comb begin
    btb_wdata.tag     = r_tag;
    btb_wdata.target  = resolve_target_EX;
    btb_wdata.cf_type = r_type;
    btb_wdata.ctr     = WT;
    if (r_hit) begin
      btb_wdata.ctr = (r_type == COND) ? ctr_next(r_line.ctr, resolve_taken_EX) : r_line.ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= '0;
    end else if (btb_we) begin
      valid_reg[r_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && btb_we) btb_reg[r_idx] <= btb_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg <= RESET_PC;
    end else if (mispredict_EX) begin
      pc_reg <= redirect_pc;
    end else if (!stall_F) begin
      pc_reg <= pred_target_F;
    end
  end

  assign ras_push = resolve_valid_EX && (r_type == CALL);
  assign ras_pop  = resolve_valid_EX && (r_type == RET);

  return_address_stack #(
    .WIDTH(WIDTH),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(resolve_pc_EX + WIDTH'(4)),
    .top      (ras_top),
    .empty    (ras_empty)
  );

endmodule
